alu_rs_issue_sched: RTL and testbench
=====================================

// Module: alu_rs_issue_sched
// PURPOSE
// Wakeup/select scheduler for the ALU reservation station. Per slot it tracks:
//   occupancy, the two source ROB tags and their ready bits, and relative age.
// Allocates free slots to the rename/dispatch stage and wakes operands on CDB broadcasts.
// Each cycle it issues the oldest fully-ready slot index to the ALU under a valid/ready handshake.
// The RS payload array (opcode, funct, operand values) is indexed by alloc_idx/issue_idx; it does not live here.
// PARAMETERS
// ALU_RS_DEPTH  3  log2 of slot count; N = 2**ALU_RS_DEPTH slots
// ROB_DEPTH     3  ROB tag width in bits
// PORTS
// clk              in   1                 clock, all state on rising edge
// rst              in   1                 asynchronous, active-high reset
// alloc_valid      in   1                 dispatch presents one instruction
// alloc_ready      out  1                 a free slot exists this cycle
// alloc_idx        out  ALU_RS_DEPTH      slot granted (lowest-index free slot)
// alloc_rs1_tag    in   ROB_DEPTH         producer tag of rs1
// alloc_rs1_rdy    in   1                 rs1 value already available
// alloc_rs2_tag    in   ROB_DEPTH         producer tag of rs2
// alloc_rs2_rdy    in   1                 rs2 value available (1 for imm forms)
// cdb_valid        in   1                 CDB broadcast this cycle
// cdb_tag          in   ROB_DEPTH         ROB tag being broadcast
// issue_valid      out  1                 issue_idx holds a ready slot
// issue_idx        out  ALU_RS_DEPTH      oldest ready slot
// issue_ready      in   1                 ALU accepts the issue this cycle
// flush            in   1                 mispredict/exception squash
// free_slot_count  out  ALU_RS_DEPTH+1    number of unoccupied slots, 0..N
// BEHAVIOUR
// Reset (async): all slots invalid, ready bits 0, age matrix 0. free_slot_count=N, issue_valid=0.
//   alloc_ready=1 and alloc_idx=0 after reset.
// Alloc fires on alloc_valid&&alloc_ready. Chosen slot becomes valid next edge.
//   Src ready bit = alloc_rsX_rdy | (cdb_valid && cdb_tag==alloc_rsX_tag), a same-cycle bypass.
// alloc_ready/alloc_idx: combinational from registered occupancy only.
//   A slot freed by issue this cycle is not reusable until next cycle.
// Wakeup: every valid slot with a matching unready tag sets that ready bit at the edge.
//   Both sources may wake on one broadcast.
// Select: combinational from registered state. Eligible = valid & rs1_rdy & rs2_rdy.
//   Picks the eligible slot with no older eligible slot; issue_valid = any eligible.
//   CDB wakeup in cycle C makes a slot eligible in C+1; there is no same-cycle wakeup-issue.
// Issue fires on issue_valid&&issue_ready: slot invalid next edge.
//   If issue_ready=0, issue_idx may change next cycle when an older slot becomes eligible.
//   No hold requirement.
// Age matrix: older[i][j]=1 means i was allocated before j.
//   On alloc to k: row k cleared; column k set to current valid vector (minus any slot issuing).
//   Freed slots have row and column cleared.
// free_slot_count next = count + issue_fire - alloc_fire. Never below 0 or above N (assertion).
// Flush: highest priority. Next edge all slots invalid, count=N; alloc/issue that cycle dropped.
//   issue_valid stays combinational and is not forced to 0 in the flush cycle.
//   The consumer gates issue with flush.
// Full (count=0): alloc_ready=0, alloc_idx=0 (don't-care). Empty: issue_valid=0.
// Simultaneous alloc+issue+wakeup in one cycle is legal; the effects are independent as above.
// STRUCTURE
// Package alu_rs_pkg: rob_tag_t [ROB_DEPTH-1:0], rs_idx_t [ALU_RS_DEPTH-1:0].
//   Also holds ALU_RS_NUM_ELEMS and the shared CDB struct cdb_t {valid, tag}.
// Sub-module age_oldest_sel (N-bit eligible vector + age matrix in; one-hot/index + any out).
//   Pure combinational; reused by future mem/branch RS schedulers.
// Free-slot priority encoder and tag CAM stay inline.
// TESTING
// 1 Reset mid-run with 5 slots valid -> same cycle: count=8, issue_valid=0, alloc_ready=1, alloc_idx=0.
// 2 Alloc A (rdy,rdy), then B (rdy,rdy) -> issue_idx=A; after A issues, issue_idx=B.
// 3 Alloc 8 entries, all waiting tag 5 -> count=0, alloc_ready=0. CDB tag 5 in C -> issue_valid=1 in C+1.
//   Issue order is allocation order, not slot order.
// 4 Alloc with rs1_tag=3, rs1_rdy=0 while cdb_tag=3 -> slot eligible next cycle; no second wakeup needed.
// 5 Full RS, issue_ready=1 and alloc_valid=1 same cycle -> alloc rejected.
//   Next cycle count=1, alloc_idx = the freed slot.
// 6 Flush with alloc_valid=1, issue_ready=1, 4 slots valid -> next cycle count=8, issue_valid=0.
//   No slot occupied.

Source files
------------

// File: rtl/alu_rs_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_rs_pkg
// Purpose : Shared sizes and types for the ALU reservation-station scheduler.
//           Holds the slot/tag widths, the slot count, the index/tag/count
//           typedefs and the common data bus broadcast struct.
// Revision: 1.0 - initial release
// ============================================================================
package alu_rs_pkg;

  localparam int ALU_RS_DEPTH     = 3;                  // log2 of slot count
  localparam int ROB_DEPTH        = 3;                  // ROB tag width
  localparam int ALU_RS_NUM_ELEMS = 2 ** ALU_RS_DEPTH;  // slot count

  typedef logic [ROB_DEPTH-1:0]    rob_tag_t;
  typedef logic [ALU_RS_DEPTH-1:0] rs_idx_t;
  typedef logic [ALU_RS_DEPTH:0]   rs_count_t;          // holds 0..N inclusive

  typedef struct packed {
    logic     valid;
    rob_tag_t tag;
  } cdb_t;

endpackage
`default_nettype wire

// File: rtl/alu_rs_issue_sched_if.sv
`default_nettype none
// ============================================================================
// Interface: alu_rs_issue_sched_if
// Purpose  : Dispatch, CDB, issue and flush signals between the pipeline
//            (master) and the ALU reservation-station scheduler (slave).
// Signals  : alloc_valid/alloc_ready/alloc_idx/alloc_rs{1,2}_{tag,rdy}
//            cdb (valid, tag), issue_valid/issue_idx/issue_ready,
//            flush, free_slot_count
// Revision : 1.0 - initial release
// ============================================================================
interface alu_rs_issue_sched_if;
  import alu_rs_pkg::*;

  logic      alloc_valid;
  logic      alloc_ready;
  rs_idx_t   alloc_idx;
  rob_tag_t  alloc_rs1_tag;
  logic      alloc_rs1_rdy;
  rob_tag_t  alloc_rs2_tag;
  logic      alloc_rs2_rdy;
  cdb_t      cdb;
  logic      issue_valid;
  rs_idx_t   issue_idx;
  logic      issue_ready;
  logic      flush;
  rs_count_t free_slot_count;

  modport master (
    output alloc_valid, alloc_rs1_tag, alloc_rs1_rdy, alloc_rs2_tag,
           alloc_rs2_rdy, cdb, issue_ready, flush,
    input  alloc_ready, alloc_idx, issue_valid, issue_idx, free_slot_count
  );

  modport slave (
    input  alloc_valid, alloc_rs1_tag, alloc_rs1_rdy, alloc_rs2_tag,
           alloc_rs2_rdy, cdb, issue_ready, flush,
    output alloc_ready, alloc_idx, issue_valid, issue_idx, free_slot_count
  );

endinterface
`default_nettype wire

// File: rtl/age_oldest_sel.sv
`default_nettype none
// ============================================================================
// Module  : age_oldest_sel
// Purpose : Pure combinational oldest-first picker driven by an age matrix.
//           older[i][j]=1 means entry i was allocated before entry j.
// Ports   : eligible  in  NUM        candidate entries
//           older     in  NUM x NUM  age matrix
//           grant     out NUM        one-hot oldest eligible entry
//           grant_idx out IDX_W      binary index of grant
//           any       out 1          at least one entry eligible
// Revision: 1.0 - initial release
// ============================================================================
module age_oldest_sel #(
  parameter int NUM   = 8,
  parameter int IDX_W = $clog2(NUM)
) (
  input  wire logic [NUM-1:0]           eligible,
  input  wire logic [NUM-1:0][NUM-1:0]  older,
  output logic      [NUM-1:0]           grant,
  output logic      [IDX_W-1:0]         grant_idx,
  output logic                          any
);

  logic blocked;

  // An eligible entry wins when no other eligible entry is older than it.
  // The matrix is a total order over occupied slots, so grant is one-hot.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    blocked   = 1'b0;
    for (int j = 0; j < NUM; j++) begin
      blocked = 1'b0;
      for (int i = 0; i < NUM; i++) begin
        blocked = blocked | (eligible[i] & older[i][j]);
      end
      grant[j] = eligible[j] & ~blocked;
    end
    for (int j = 0; j < NUM; j++) begin
      if (grant[j]) grant_idx = grant_idx | IDX_W'(j);
    end
  end

  assign any = |eligible;

endmodule
`default_nettype wire

// File: rtl/alu_rs_issue_sched.sv
`default_nettype none
// ============================================================================
// Module  : alu_rs_issue_sched
// Purpose : Wakeup/select scheduler for the ALU reservation station. Tracks
//           per-slot occupancy, source tags/ready bits and relative age;
//           grants the lowest free slot to dispatch, wakes sources on CDB
//           broadcasts and issues the oldest fully-ready slot.
// Ports   : clk  in  1   clock, rising edge
//           rst  in  1   asynchronous active-high reset
//           bus  slave   alloc / cdb / issue / flush / free_slot_count
// Revision: 1.0 - initial release
// ============================================================================
module alu_rs_issue_sched
  import alu_rs_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst,
  alu_rs_issue_sched_if.slave   bus
);

  localparam int N = ALU_RS_NUM_ELEMS;

  logic [N-1:0]          valid;
  logic [N-1:0]          rs1_rdy;
  logic [N-1:0]          rs2_rdy;
  rob_tag_t [N-1:0]      rs1_tag;
  rob_tag_t [N-1:0]      rs2_tag;
  logic [N-1:0][N-1:0]   older;
  logic [N-1:0][N-1:0]   older_nxt;
  rs_count_t             count;

  logic                  alloc_ready_c;
  rs_idx_t               alloc_idx_c;
  logic                  alloc_fire;
  logic                  issue_fire;
  logic [N-1:0]          alloc_mask;
  logic [N-1:0]          issue_mask;
  logic [N-1:0]          eligible;
  logic [N-1:0]          grant;
  rs_idx_t               issue_idx_c;
  logic                  issue_valid_c;
  logic [N-1:0]          rs1_hit;
  logic [N-1:0]          rs2_hit;
  logic                  alloc_rs1_hit;
  logic                  alloc_rs2_hit;

  // Lowest-index free slot; sees only registered occupancy so a slot
  // freed by this cycle's issue is not offered until the next cycle.
  always_comb begin
    alloc_ready_c = 1'b0;
    alloc_idx_c   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        alloc_ready_c = 1'b1;
        alloc_idx_c   = rs_idx_t'(i);
      end
    end
  end

  // Tag CAM against the broadcast, including the same-cycle dispatch bypass.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rs1_hit[i] = bus.cdb.valid && (rs1_tag[i] == bus.cdb.tag);
      rs2_hit[i] = bus.cdb.valid && (rs2_tag[i] == bus.cdb.tag);
    end
  end
  assign alloc_rs1_hit = bus.cdb.valid && (bus.alloc_rs1_tag == bus.cdb.tag);
  assign alloc_rs2_hit = bus.cdb.valid && (bus.alloc_rs2_tag == bus.cdb.tag);

  assign eligible = valid & rs1_rdy & rs2_rdy;

  age_oldest_sel #(
    .NUM   (N),
    .IDX_W (ALU_RS_DEPTH)
  ) u_sel (
    .eligible  (eligible),
    .older     (older),
    .grant     (grant),
    .grant_idx (issue_idx_c),
    .any       (issue_valid_c)
  );

  assign alloc_fire = bus.alloc_valid & alloc_ready_c;
  assign issue_fire = issue_valid_c & bus.issue_ready;
  assign alloc_mask = alloc_fire ? (N'(1) << alloc_idx_c) : '0;
  assign issue_mask = issue_fire ? grant : '0;

  // Age update: a new slot is younger than every slot that stays occupied;
  // an issuing slot drops out of the ordering entirely.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        older_nxt[i][j] = older[i][j];
        if (issue_mask[i] || issue_mask[j]) older_nxt[i][j] = 1'b0;
        if (alloc_mask[i])                  older_nxt[i][j] = 1'b0;
        if (alloc_mask[j])                  older_nxt[i][j] = valid[i] & ~issue_mask[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= '0;
      rs1_rdy <= '0;
      rs2_rdy <= '0;
      rs1_tag <= '0;
      rs2_tag <= '0;
      older   <= '0;
      count   <= rs_count_t'(N);
    end else if (bus.flush) begin
      valid   <= '0;
      rs1_rdy <= '0;
      rs2_rdy <= '0;
      older   <= '0;
      count   <= rs_count_t'(N);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (issue_mask[i]) valid[i] <= 1'b0;
        if (alloc_mask[i]) begin
          valid[i]   <= 1'b1;
          rs1_tag[i] <= bus.alloc_rs1_tag;
          rs2_tag[i] <= bus.alloc_rs2_tag;
          rs1_rdy[i] <= bus.alloc_rs1_rdy | alloc_rs1_hit;
          rs2_rdy[i] <= bus.alloc_rs2_rdy | alloc_rs2_hit;
        end else if (valid[i]) begin
          if (rs1_hit[i]) rs1_rdy[i] <= 1'b1;
          if (rs2_hit[i]) rs2_rdy[i] <= 1'b1;
        end
      end
      older <= older_nxt;
      count <= count + rs_count_t'(issue_fire) - rs_count_t'(alloc_fire);
    end
  end

  assign bus.alloc_ready     = alloc_ready_c;
  assign bus.alloc_idx       = alloc_idx_c;
  assign bus.issue_valid     = issue_valid_c;
  assign bus.issue_idx       = issue_idx_c;
  assign bus.free_slot_count = count;

  // The free counter must stay within 0..N and agree with occupancy.
  a_count_range : assert property (@(posedge clk) disable iff (rst)
    (count <= rs_count_t'(N)) && (32'(count) == N - $countones(valid)));

endmodule
`default_nettype wire

// File: tb/tb_alu_rs_issue_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_rs_issue_sched
// Purpose : Self-checking bench for alu_rs_issue_sched. A reference model of
//           the station (slots with sequence numbers, oldest = lowest
//           sequence) predicts each cycle's outputs into a queue; a monitor
//           pops and compares them against the DUT.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_rs_issue_sched;
  import alu_rs_pkg::*;

  localparam int N = ALU_RS_NUM_ELEMS;

  typedef struct {
    bit ar;
    int ai;
    bit iv;
    int ii;
    int cnt;
  } exp_t;

  logic clk;
  logic rst;
  alu_rs_issue_sched_if bus();

  alu_rs_issue_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests;
  int   fails;
  exp_t exp_q[$];

  // Reference state: per-slot occupancy, tags, ready flags and allocation order.
  bit       m_valid[N];
  bit       m_r1[N];
  bit       m_r2[N];
  int       m_t1[N];
  int       m_t2[N];
  int       m_seq[N];
  int       seq_ctr;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
    end
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    int   best;
    e.ar = 0; e.ai = 0; e.iv = 0; e.ii = 0; e.cnt = 0;
    best = 32'h7fffffff;
    for (int i = N - 1; i >= 0; i--) begin
      if (!m_valid[i]) begin
        e.ar = 1; e.ai = i; e.cnt++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_r1[i] && m_r2[i] && m_seq[i] < best) begin
        best = m_seq[i]; e.iv = 1; e.ii = i;
      end
    end
    return e;
  endfunction

  task automatic step(input bit av, input int t1, input bit r1, input int t2,
                      input bit r2, input bit cv, input int ct, input bit ir,
                      input bit fl);
    exp_t e;
    @(negedge clk);
    bus.alloc_valid   = av;
    bus.alloc_rs1_tag = rob_tag_t'(t1);
    bus.alloc_rs1_rdy = r1;
    bus.alloc_rs2_tag = rob_tag_t'(t2);
    bus.alloc_rs2_rdy = r2;
    bus.cdb.valid     = cv;
    bus.cdb.tag       = rob_tag_t'(ct);
    bus.issue_ready   = ir;
    bus.flush         = fl;
    e = model_outputs();
    exp_q.push_back(e);
    if (fl) begin
      model_clear();
    end else begin
      if (cv) begin
        for (int i = 0; i < N; i++) begin
          if (m_valid[i] && m_t1[i] == ct) m_r1[i] = 1;
          if (m_valid[i] && m_t2[i] == ct) m_r2[i] = 1;
        end
      end
      if (e.iv && ir) m_valid[e.ii] = 0;
      if (av && e.ar) begin
        m_valid[e.ai] = 1;
        m_t1[e.ai]    = t1;
        m_t2[e.ai]    = t2;
        m_r1[e.ai]    = r1 || (cv && t1 == ct);
        m_r2[e.ai]    = r2 || (cv && t2 == ct);
        m_seq[e.ai]   = seq_ctr++;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares every predicted cycle against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("alloc_ready", int'(bus.alloc_ready), int'(e.ar));
        chk("alloc_idx", int'(bus.alloc_idx), e.ai);
        chk("issue_valid", int'(bus.issue_valid), int'(e.iv));
        if (e.iv) chk("issue_idx", int'(bus.issue_idx), e.ii);
        chk("free_slot_count", int'(bus.free_slot_count), e.cnt);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0; seq_ctr = 0;
    model_clear();
    rst = 1'b1;
    bus.alloc_valid = 0; bus.alloc_rs1_tag = '0; bus.alloc_rs1_rdy = 0;
    bus.alloc_rs2_tag = '0; bus.alloc_rs2_rdy = 0; bus.cdb = '0;
    bus.issue_ready = 0; bus.flush = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state, then asynchronous reset mid-run with five occupied slots.
    idle();
    for (int k = 0; k < 5; k++) step(1, k, 0, 7, 0, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    bus.alloc_valid = 0; bus.issue_ready = 0; bus.cdb = '0; bus.flush = 0;
    rst = 1'b1;
    #1;
    chk("rst_count", int'(bus.free_slot_count), N);
    chk("rst_issue_valid", int'(bus.issue_valid), 0);
    chk("rst_alloc_ready", int'(bus.alloc_ready), 1);
    chk("rst_alloc_idx", int'(bus.alloc_idx), 0);
    #3;
    rst = 1'b0;
    model_clear();

    // Two ready entries issue in allocation order.
    step(1, 1, 1, 2, 1, 0, 0, 0, 0);
    step(1, 3, 1, 4, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();

    // Fill with older ready pair, waiting six, free the pair, refill: full,
    // then one broadcast wakes all; issue order follows allocation order.
    step(1, 0, 1, 0, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 5, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 5, 0, 5, 0, 0, 0, 0, 0);
    step(1, 1, 1, 5, 0, 0, 0, 0, 0);
    step(1, 2, 1, 2, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5, 0, 0);
    for (int k = 0; k < 9; k++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Dispatch with same-cycle broadcast bypass.
    step(1, 3, 0, 6, 1, 1, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle();

    // Full station: alloc rejected while issue frees a slot.
    for (int k = 0; k < N; k++) step(1, k, 1, k, 1, 0, 0, 0, 0);
    step(1, 2, 1, 2, 1, 0, 0, 1, 0);
    idle();
    step(1, 4, 1, 4, 1, 0, 0, 0, 0);

    // Flush with four occupied slots and alloc/issue requested.
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) step(1, k, 1, k, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 0, 1, 1);
    idle();

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      step($urandom_range(0, 99) < 70, $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 99) < 50,
           $urandom_range(0, 99) < 2);
    end
    idle();

    @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
